// File: rtl/q2_mem_arbiter_pkg.sv
// Shared widths, DMA sequencer state encoding and the latched DMA command record
// for the q2 memory arbiter.
package q2_mem_arbiter_pkg;

  localparam int AW     = 12;
  localparam int DW     = 12;
  localparam int IO_BIT = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_ADDR = 2'd1,
    D_STB  = 2'd2,
    D_DONE = 2'd3
  } dma_state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dma_cmd_t;

  function automatic logic is_io_page(input logic [AW-1:0] a);
    return a[IO_BIT];
  endfunction

endpackage

// File: rtl/q2_mem_arbiter_if.sv
// CPU, DMA, RAM and I/O-port signal bundle around the arbiter; slave is the arbiter
// view, master is the view of everything attached to it.
interface q2_mem_arbiter_if;
  import q2_mem_arbiter_pkg::*;

  logic [AW-1:0] cpu_abus;
  logic [DW-1:0] cpu_dout;
  logic [DW-1:0] cpu_din;
  logic          cpu_rdm;
  logic          cpu_wrm;
  logic          cpu_run;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          dma_busy;

  logic [AW-1:0] mem_abus;
  logic [DW-1:0] mem_dout;
  logic          mem_oe;
  logic [DW-1:0] mem_din;
  logic          mem_rdm;
  logic          mem_wrm;

  logic          io_wr;
  logic [AW-2:0] io_addr;
  logic [DW-1:0] io_data;
  logic          conflict;

  modport slave (
    input  cpu_abus, cpu_dout, cpu_rdm, cpu_wrm, cpu_run,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_din,
    output cpu_din, dma_ack, dma_rdata, dma_busy,
    output mem_abus, mem_dout, mem_oe, mem_rdm, mem_wrm,
    output io_wr, io_addr, io_data, conflict
  );

  modport master (
    output cpu_abus, cpu_dout, cpu_rdm, cpu_wrm, cpu_run,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_din,
    input  cpu_din, dma_ack, dma_rdata, dma_busy,
    input  mem_abus, mem_dout, mem_oe, mem_rdm, mem_wrm,
    input  io_wr, io_addr, io_data, conflict
  );

endinterface

// File: rtl/q2_io_decode.sv
// CPU write-strobe edge detect and I/O page output register: one-cycle io_wr pulse the
// cycle after a rising wrm with the I/O bit set; no backpressure, held wrm pulses once.
module q2_io_decode
  import q2_mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wrm,
  input  logic [AW-1:0] i_abus,
  input  logic [DW-1:0] i_dout,
  output logic          o_io_wr,
  output logic [AW-2:0] o_io_addr,
  output logic [DW-1:0] o_io_data
);

  logic          r_wrm_d;
  logic          r_io_wr;
  logic [AW-2:0] r_io_addr;
  logic [DW-1:0] r_io_data;
  logic          w_hit;

  assign w_hit = i_wrm & ~r_wrm_d & is_io_page(i_abus);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrm_d   <= 1'b0;
      r_io_wr   <= 1'b0;
      r_io_addr <= '0;
      r_io_data <= '0;
    end else begin
      r_wrm_d <= i_wrm;
      r_io_wr <= w_hit;
      if (w_hit) begin
        r_io_addr <= i_abus[AW-2:0];
        r_io_data <= i_dout;
      end
    end
  end

  assign o_io_wr   = r_io_wr;
  assign o_io_addr = r_io_addr;
  assign o_io_data = r_io_data;

endmodule

// File: rtl/q2_mem_arbiter.sv
// Memory bus arbiter: CPU pass-through while idle, 4-cycle DMA sequence (ack 3 cycles after
// grant) only while the CPU is halted; any CPU strobe pre-empts DMA immediately.
module q2_mem_arbiter
  import q2_mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  q2_mem_arbiter_if.slave  bus
);

  dma_state_t    r_state;
  dma_state_t    w_next;
  dma_cmd_t      r_cmd;
  logic [DW-1:0] r_rdata;
  logic          r_conflict;

  logic w_cpu_stb;
  logic w_grant;
  logic w_clash;
  logic w_dma_own;

  assign w_cpu_stb = bus.cpu_rdm | bus.cpu_wrm;
  assign w_grant   = (r_state == IDLE) & bus.dma_req & ~bus.cpu_run & ~w_cpu_stb;
  assign w_clash   = (r_state != IDLE) & w_cpu_stb;
  assign w_dma_own = (r_state != IDLE) & ~w_cpu_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_next = D_ADDR;
      D_ADDR:  w_next = D_STB;
      D_STB:   w_next = D_DONE;
      D_DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // A CPU strobe abandons the DMA access; a still-held request is re-granted later.
    if (w_clash) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= '0;
      r_rdata    <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_grant)
        r_cmd <= '{we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};
      if (w_dma_own && (r_state == D_STB) && !r_cmd.we)
        r_rdata <= bus.mem_din;
      if (w_clash)
        r_conflict <= 1'b1;
    end
  end

  // Bus mux; everything is forced low while reset is asserted.
  always_comb begin
    bus.mem_abus = '0;
    bus.mem_dout = '0;
    bus.mem_oe   = 1'b0;
    bus.mem_rdm  = 1'b0;
    bus.mem_wrm  = 1'b0;
    bus.cpu_din  = '0;
    if (rst_n) begin
      bus.cpu_din = bus.mem_din;
      if (w_dma_own) begin
        bus.mem_abus = r_cmd.addr;
        bus.mem_dout = r_cmd.wdata;
        bus.mem_oe   = r_cmd.we;
        bus.mem_rdm  = (r_state == D_STB) & ~r_cmd.we;
        bus.mem_wrm  = (r_state == D_STB) &  r_cmd.we;
      end else begin
        bus.mem_abus = bus.cpu_abus;
        bus.mem_dout = bus.cpu_dout;
        bus.mem_oe   = bus.cpu_wrm;
        bus.mem_rdm  = bus.cpu_rdm;
        bus.mem_wrm  = bus.cpu_wrm;
      end
    end
  end

  assign bus.dma_ack   = w_dma_own & (r_state == D_DONE);
  assign bus.dma_rdata = r_rdata;
  assign bus.dma_busy  = (r_state != IDLE);
  assign bus.conflict  = r_conflict;

  q2_io_decode u_io_decode (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wrm     (bus.cpu_wrm),
    .i_abus    (bus.cpu_abus),
    .i_dout    (bus.cpu_dout),
    .o_io_wr   (bus.io_wr),
    .o_io_addr (bus.io_addr),
    .o_io_data (bus.io_data)
  );

endmodule

// File: tb/tb_q2_mem_arbiter.sv
// Directed bench for q2_mem_arbiter: expected DMA acks and I/O strobes are queued by the
// stimulus and popped by an independent monitor; bus timing is checked inline.
module tb_q2_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  q2_mem_arbiter_if bus ();

  q2_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [11:0] mem [4096];
  assign bus.mem_din = mem[bus.mem_abus];
  always @(posedge bus.mem_wrm) mem[bus.mem_abus] <= bus.mem_dout;

  typedef struct packed {
    logic [10:0] addr;
    logic [11:0] data;
  } io_exp_t;

  logic [11:0] exp_ack[$];
  io_exp_t     exp_io[$];
  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.dma_ack) begin
      if (exp_ack.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL ack_unexpected: got ack with rdata 0x%0h, none expected at %0t", bus.dma_rdata, $time);
      end else begin
        check("ack_rdata", 32'(bus.dma_rdata), 32'(exp_ack.pop_front()));
      end
    end
    if (rst_n && bus.io_wr) begin
      if (exp_io.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL io_unexpected: got io_wr addr 0x%0h data 0x%0h, none expected at %0t",
                 bus.io_addr, bus.io_data, $time);
      end else begin
        io_exp_t e;
        e = exp_io.pop_front();
        check("io_addr", 32'(bus.io_addr), 32'(e.addr));
        check("io_data", 32'(bus.io_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dma_issue(input logic we, input logic [11:0] addr, input logic [11:0] wdata);
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
    bus.dma_req   = 1'b1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.dma_ack && n < 20);
    check("ack_seen", 32'(bus.dma_ack), 32'd1);
    bus.dma_req = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_abus"}, 32'(bus.mem_abus), 32'd0);
    check({tag, "_mem_wrm"},  32'(bus.mem_wrm),  32'd0);
    check({tag, "_mem_rdm"},  32'(bus.mem_rdm),  32'd0);
    check({tag, "_mem_oe"},   32'(bus.mem_oe),   32'd0);
    check({tag, "_busy"},     32'(bus.dma_busy), 32'd0);
    check({tag, "_ack"},      32'(bus.dma_ack),  32'd0);
    check({tag, "_rdata"},    32'(bus.dma_rdata), 32'd0);
    check({tag, "_conflict"}, 32'(bus.conflict), 32'd0);
    check({tag, "_io_wr"},    32'(bus.io_wr),    32'd0);
    check({tag, "_io_data"},  32'(bus.io_data),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.cpu_abus = '0; bus.cpu_dout = '0; bus.cpu_rdm = 1'b0; bus.cpu_wrm = 1'b0;
    bus.cpu_run  = 1'b1;
    bus.dma_req  = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.cpu_abus = 12'h3C3;
    #1;
    check_reset_outputs("rst0");
    bus.cpu_abus = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: CPU pass-through while running
    bus.cpu_abus = 12'h123; bus.cpu_dout = 12'hABC;
    #1 bus.cpu_wrm = 1'b1;
    #1;
    check("t1_abus", 32'(bus.mem_abus), 32'h123);
    check("t1_dout", 32'(bus.mem_dout), 32'hABC);
    check("t1_wrm",  32'(bus.mem_wrm),  32'd1);
    check("t1_oe",   32'(bus.mem_oe),   32'd1);
    tick();
    bus.cpu_wrm = 1'b0;
    tick();
    bus.cpu_rdm = 1'b1;
    #1;
    check("t1_rdm",  32'(bus.mem_rdm),  32'd1);
    check("t1_din",  32'(bus.cpu_din),  32'hABC);
    check("t1_busy", 32'(bus.dma_busy), 32'd0);
    bus.cpu_rdm = 1'b0;
    tick();

    // 2: halted CPU, DMA write then read-back
    bus.cpu_run = 1'b0;
    exp_ack.push_back(12'h000);
    dma_issue(1'b1, 12'h7FF, 12'h555);
    tick();
    check("t2_addr_busy", 32'(bus.dma_busy), 32'd1);
    check("t2_addr_abus", 32'(bus.mem_abus), 32'h7FF);
    check("t2_addr_oe",   32'(bus.mem_oe),   32'd1);
    check("t2_addr_wrm",  32'(bus.mem_wrm),  32'd0);
    tick();
    check("t2_stb_wrm",   32'(bus.mem_wrm),  32'd1);
    check("t2_stb_rdm",   32'(bus.mem_rdm),  32'd0);
    check("t2_stb_dout",  32'(bus.mem_dout), 32'h555);
    tick();
    check("t2_done_ack",  32'(bus.dma_ack),  32'd1);
    check("t2_done_wrm",  32'(bus.mem_wrm),  32'd0);
    check("t2_done_abus", 32'(bus.mem_abus), 32'h7FF);
    bus.dma_req = 1'b0;
    tick();
    check("t2_idle_busy", 32'(bus.dma_busy), 32'd0);
    exp_ack.push_back(12'h555);
    dma_issue(1'b0, 12'h7FF, 12'h000);
    wait_ack(n);
    check("t2_rd_latency", 32'(n), 32'd3);

    // 3: request held off while the CPU runs
    bus.cpu_run = 1'b1;
    exp_ack.push_back(12'hABC);
    dma_issue(1'b0, 12'h123, 12'h000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_grant", 32'(bus.dma_busy), 32'd0);
    end
    bus.cpu_run = 1'b0;
    wait_ack(n);
    check("t3_latency", 32'(n), 32'd3);

    // 4: CPU write to the I/O page, then a DMA write there must not strobe io_wr
    bus.cpu_run = 1'b1;
    bus.cpu_abus = 12'h805; bus.cpu_dout = 12'h0FA;
    exp_io.push_back('{addr: 11'h005, data: 12'h0FA});
    #1 bus.cpu_wrm = 1'b1;
    tick();
    check("t4_io_pulse", 32'(bus.io_wr), 32'd1);
    tick();
    check("t4_io_once",  32'(bus.io_wr), 32'd0);
    bus.cpu_wrm = 1'b0;
    tick();
    bus.cpu_rdm = 1'b1;
    #1;
    check("t4_ram_updated", 32'(bus.cpu_din), 32'h0FA);
    bus.cpu_rdm = 1'b0;
    bus.cpu_run = 1'b0;
    exp_ack.push_back(12'hABC);
    dma_issue(1'b1, 12'h9AA, 12'h321);
    wait_ack(n);
    tick(); tick();

    // 5: CPU strobe pre-empts DMA during address setup
    exp_ack.push_back(12'h555);
    dma_issue(1'b0, 12'h7FF, 12'h000);
    tick();
    bus.cpu_abus = 12'h123;
    bus.cpu_rdm  = 1'b1;
    #1;
    check("t5_abus_cpu", 32'(bus.mem_abus), 32'h123);
    check("t5_rdm_cpu",  32'(bus.mem_rdm),  32'd1);
    check("t5_din_cpu",  32'(bus.cpu_din),  32'hABC);
    check("t5_no_ack",   32'(bus.dma_ack),  32'd0);
    tick();
    check("t5_conflict", 32'(bus.conflict), 32'd1);
    check("t5_idle",     32'(bus.dma_busy), 32'd0);
    tick();
    check("t5_held_off", 32'(bus.dma_busy), 32'd0);
    bus.cpu_rdm = 1'b0;
    wait_ack(n);
    check("t5_retry_latency", 32'(n), 32'd3);
    check("t5_sticky",  32'(bus.conflict), 32'd1);

    // 6: reset during the strobe cycle
    dma_issue(1'b1, 12'h010, 12'h777);
    tick();
    tick();
    check("t6_stb_wrm", 32'(bus.mem_wrm), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    bus.dma_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    exp_ack.push_back(12'h555);
    dma_issue(1'b0, 12'h7FF, 12'h000);
    wait_ack(n);
    check("t6_post_latency", 32'(n), 32'd3);

    tick(); tick();
    check("ack_queue_drained", 32'(exp_ack.size()), 32'd0);
    check("io_queue_drained",  32'(exp_io.size()),  32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
